hc165_scan_reader: RTL and testbench

- Reader-side counterpart to the board's 74HC595 output drivers.
- Scans a daisy-chain of 74HC165 parallel-in/serial-out shift registers: front-panel range switches, relay/attenuator readback bits and status lines.
- Pulses parallel load, clocks the chain serially, assembles a parallel word and presents it to the measurement controller with a one-cycle valid strobe.
- Free-running while enabled.

---
 rtl/hc165_scan_reader.sv | 143 ++++++++++++++
 tb/tb_hc165_scan_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc165_scan_reader.sv
// 74HC165 chain scanner: parallel load, shift 8*N_DEV bits, publish with a one-cycle o_valid.
// Latency (16*N_DEV+1)*CLK_DIV+1 cycles, no backpressure; HC165_DEBOUNCE_EN publishes only on two equal frames.
module hc165_scan_reader #(
   parameter int N_DEV   = 1,
   parameter int CLK_DIV = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_scan_en,
   input  logic               i_QH,
   output logic               o_SH_LD_n,
   output logic               o_CLK,
   output logic               o_CLK_INH,
   output logic [8*N_DEV-1:0] o_data,
   output logic               o_valid,
   output logic               o_busy
);

   localparam int W     = 8 * N_DEV;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_cnt_nxt;
   logic [BIT_W-1:0] bit_cnt;
   logic [BIT_W-1:0] bit_cnt_nxt;
   logic [W-2:0]     shift_q;
   logic [W-1:0]     frame;
   logic             phase_end;
   logic             publish;

   // The bit being sampled now completes the frame, so DONE can publish it directly.
   assign frame     = {shift_q, i_QH};
   assign phase_end = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt   = state;
      div_cnt_nxt = div_cnt;
      bit_cnt_nxt = bit_cnt;
      case (state)
         IDLE: begin
            div_cnt_nxt = '0;
            if (i_scan_en) state_nxt = LOAD;
         end
         LOAD: begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
            if (phase_end) begin
               div_cnt_nxt = '0;
               state_nxt   = SETTLE;
            end
         end
         SETTLE: begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
            if (phase_end) begin
               div_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               state_nxt   = LOW;
            end
         end
         LOW: begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
            if (phase_end) begin
               div_cnt_nxt = '0;
               state_nxt   = (bit_cnt == BIT_LAST) ? DONE : HIGH;
            end
         end
         HIGH: begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
            if (phase_end) begin
               div_cnt_nxt = '0;
               bit_cnt_nxt = bit_cnt + BIT_W'(1);
               state_nxt   = LOW;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef HC165_DEBOUNCE_EN
   logic [W-1:0] raw_q;
   logic         raw_vld;

   assign publish = raw_vld && (frame == raw_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         raw_q   <= '0;
         raw_vld <= 1'b0;
      end else if (state_nxt == DONE) begin
         raw_q   <= frame;
         raw_vld <= 1'b1;
      end
   end
`else
   assign publish = 1'b1;
`endif

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         o_SH_LD_n <= 1'b1;
         o_CLK     <= 1'b0;
         o_CLK_INH <= 1'b1;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         if ((state == LOW) && phase_end) shift_q <= frame[W-2:0];
         o_SH_LD_n <= (state_nxt != LOAD);
         o_CLK     <= (state_nxt == HIGH);
         o_CLK_INH <= (state_nxt == IDLE);
         o_busy    <= (state_nxt != IDLE);
         o_valid   <= (state_nxt == DONE) && publish;
         if ((state_nxt == DONE) && publish) o_data <= frame;
      end
   end

endmodule

// File: tb/tb_hc165_scan_reader.sv
// Bench for hc165_scan_reader: three configurations, each fed by a behavioural 74HC165 chain.
module tb_hc165_scan_reader;

   localparam int NI = 3;

   function automatic int ndev(input int g);
      return (g == 1) ? 2 : 1;
   endfunction

   function automatic int div(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   function automatic bit [15:0] wmask(input int g);
      return (ndev(g) == 2) ? 16'hFFFF : 16'h00FF;
   endfunction

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [NI-1:0] scan_en;
   logic [NI-1:0] qh;
   logic [NI-1:0] sh_ld_n;
   logic [NI-1:0] sclk;
   logic [NI-1:0] clk_inh;
   logic [NI-1:0] valid;
   logic [NI-1:0] busy;
   logic [7:0]    data0;
   logic [15:0]   data1;
   logic [7:0]    data2;
   logic [15:0]   dat [NI];

   assign dat[0] = {8'h00, data0};
   assign dat[1] = data1;
   assign dat[2] = {8'h00, data2};

   always #5 i_clk = ~i_clk;

   hc165_scan_reader #(.N_DEV(1), .CLK_DIV(2)) u_dut0 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scan_en(scan_en[0]), .i_QH(qh[0]),
      .o_SH_LD_n(sh_ld_n[0]), .o_CLK(sclk[0]), .o_CLK_INH(clk_inh[0]),
      .o_data(data0), .o_valid(valid[0]), .o_busy(busy[0]));

   hc165_scan_reader #(.N_DEV(2), .CLK_DIV(1)) u_dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scan_en(scan_en[1]), .i_QH(qh[1]),
      .o_SH_LD_n(sh_ld_n[1]), .o_CLK(sclk[1]), .o_CLK_INH(clk_inh[1]),
      .o_data(data1), .o_valid(valid[1]), .o_busy(busy[1]));

   hc165_scan_reader #(.N_DEV(1), .CLK_DIV(4)) u_dut2 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scan_en(scan_en[2]), .i_QH(qh[2]),
      .o_SH_LD_n(sh_ld_n[2]), .o_CLK(sclk[2]), .o_CLK_INH(clk_inh[2]),
      .o_data(data2), .o_valid(valid[2]), .o_busy(busy[2]));

   // Chain model: loads while SH/LD is low, shifts one system clock after each serial clock rise.
   bit [15:0]   par     [NI];
   bit [15:0]   chain   [NI];
   bit [15:0]   fix_val [NI];
   bit [NI-1:0] fix_on;
   bit [NI-1:0] ck_seen;
   int unsigned cyc;

   always @(posedge i_clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < NI; g++) begin
         if (fix_on[g]) par[g] <= fix_val[g];
         else if (!busy[g] && ($urandom_range(1, 0) == 1)) par[g] <= 16'($urandom) & wmask(g);
         if (!sh_ld_n[g]) chain[g] <= par[g];
         else if (!clk_inh[g] && sclk[g] && !ck_seen[g]) chain[g] <= chain[g] << 1;
         ck_seen[g] <= sclk[g];
      end
   end

   always_comb begin
      qh = '0;
      for (int g = 0; g < NI; g++) qh[g] = chain[g][8*ndev(g)-1];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      for (int g = 0; g < NI; g++) begin
         check({tag, "_sh_ld_n"}, sh_ld_n[g], 1);
         check({tag, "_clk"}, sclk[g], 0);
         check({tag, "_clk_inh"}, clk_inh[g], 1);
         check({tag, "_data"}, dat[g], 0);
         check({tag, "_valid"}, valid[g], 0);
         check({tag, "_busy"}, busy[g], 0);
      end
   endtask

   // Frame-level reference: every completed frame must show the specified waveform shape,
   // publish (or not) by the debounce rule, and leave o_data equal to the last published frame.
   bit          busy_d   [NI];
   bit          ck_d2    [NI];
   bit          vld_d    [NI];
   bit          got_vld  [NI];
   bit          have_raw [NI];
   bit [15:0]   prev_raw [NI];
   bit [15:0]   last_pub [NI];
   int          rises    [NI];
   int          ld_cnt   [NI];
   int          hi_run   [NI];
   int unsigned start_cyc [NI];
   int unsigned last_rise [NI];

   task automatic monitor_step();
      bit        pub;
      bit [15:0] frame;
      for (int g = 0; g < NI; g++) begin
         if (!i_rst_n) begin
            busy_d[g] = 0; ck_d2[g] = 0; vld_d[g] = 0; got_vld[g] = 0;
            have_raw[g] = 0; last_pub[g] = 0; hi_run[g] = 0; rises[g] = 0;
         end else begin
            if (busy[g] && !busy_d[g]) begin
               start_cyc[g] = cyc; rises[g] = 0; ld_cnt[g] = 0; got_vld[g] = 0;
            end
            if (!sh_ld_n[g]) ld_cnt[g]++;
            if (sclk[g] && !ck_d2[g]) begin
               if (rises[g] > 0) check("rise_spacing", cyc - last_rise[g], 2 * div(g));
               rises[g]++;
               last_rise[g] = cyc;
            end
            if (sclk[g]) hi_run[g]++;
            else if (ck_d2[g]) begin
               check("clk_high_len", hi_run[g], div(g));
               hi_run[g] = 0;
            end
            if (valid[g]) begin
               check("vld_one_cycle", vld_d[g], 0);
               check("vld_in_frame", busy[g], 1);
               check("latency", cyc - start_cyc[g], (16 * ndev(g) + 1) * div(g));
               got_vld[g] = 1;
            end
            if (!busy[g] && busy_d[g]) begin
               frame = par[g] & wmask(g);
`ifdef HC165_DEBOUNCE_EN
               pub = have_raw[g] && (frame == prev_raw[g]);
`else
               pub = 1;
`endif
               check("publish", got_vld[g], pub);
               check("clk_rises", rises[g], 8 * ndev(g) - 1);
               check("load_len", ld_cnt[g], div(g));
               prev_raw[g] = frame;
               have_raw[g] = 1;
               if (pub) last_pub[g] = frame;
               check("data", dat[g], last_pub[g]);
            end
            busy_d[g] = busy[g];
            ck_d2[g]  = sclk[g];
            vld_d[g]  = valid[g];
         end
      end
   endtask

   task automatic wait_vld(input int g, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge i_clk); #1;
         if (valid[g]) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("vld_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int g, input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge i_clk); #1;
         if (!busy[g]) begin
            done = 1;
            break;
         end
      end
      if (!done) check("idle_timeout", 0, 1);
   endtask

   task automatic count_rises(input int g, input int want, input int budget, output int n);
      bit prev;
      n = 0;
      prev = sclk[g];
      for (int i = 0; (i < budget) && (n < want); i++) begin
         @(posedge i_clk); #1;
         if (sclk[g] && !prev) n++;
         prev = sclk[g];
      end
   endtask

   initial begin
      bit          ok;
      int          n;
      int unsigned t0;

      i_rst_n = 1'b0;
      scan_en = '0;
      fix_on  = '0;
      fork
         forever begin
            @(negedge i_clk);
            monitor_step();
         end
      join_none

      repeat (3) @(posedge i_clk);
      #1;
      chk_reset("rst");
      i_rst_n = 1'b1;

      // Single enable pulse, 8'hB2 on a one-device chain with CLK_DIV=2.
      fix_val[0] = 16'h00B2;
      fix_on[0]  = 1'b1;
      @(posedge i_clk); #1;
`ifdef HC165_DEBOUNCE_EN
      scan_en[0] = 1'b1;
      @(posedge i_clk); #1;
      scan_en[0] = 1'b0;
      wait_idle(0, 200);
`endif
      scan_en[0] = 1'b1;
      t0 = cyc;
      @(posedge i_clk); #1;
      scan_en[0] = 1'b0;
      wait_vld(0, 200, ok);
      if (ok) check("latency_b2", cyc - t0, 35);
      check("data_b2", dat[0], 16'h00B2);

      // Enable dropped during HIGH of bit 3: frame completes, then the block parks in IDLE.
      wait_idle(0, 20);
      scan_en[0] = 1'b1;
      count_rises(0, 4, 200, n);
      scan_en[0] = 1'b0;
      check("bit3_reached", n, 4);
      wait_vld(0, 200, ok);
      check("drop_data", dat[0], 16'h00B2);
      wait_idle(0, 50);
      repeat (10) @(posedge i_clk);
      #1;
      check("drop_busy", busy[0], 0);
      check("drop_clk_inh", clk_inh[0], 1);
      check("drop_clk", sclk[0], 0);

      // Two-device chain, CLK_DIV=1, enable held: back-to-back frames.
      fix_val[1] = 16'hA53C;
      fix_on[1]  = 1'b1;
      @(posedge i_clk); #1;
      scan_en[1] = 1'b1;
      wait_vld(1, 200, ok);
      for (int k = 0; k < 2; k++) begin
         t0 = cyc;
         wait_vld(1, 100, ok);
         if (ok) check("b2b_spacing", cyc - t0, 35);
         check("data_a53c", dat[1], 16'hA53C);
      end

      // Reset asserted in the middle of a LOW phase (CLK_DIV=4), then a clean frame.
      scan_en[2] = 1'b1;
      count_rises(2, 2, 300, n);
      check("pre_rst_rises", n, 2);
      for (int i = 0; (i < 20) && sclk[2]; i++) begin
         @(posedge i_clk); #1;
      end
      check("pre_rst_busy", busy[2], 1);
      check("pre_rst_low", sclk[2], 0);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      wait_vld(2, 300, ok);
      check("post_rst_data", dat[2], par[2] & wmask(2));

      // Random enables and random switch patterns on all three chains.
      fix_on = '0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge i_clk); #1;
         for (int g = 0; g < NI; g++)
            if ($urandom_range(39, 0) == 0) scan_en[g] = ($urandom_range(3, 0) != 0);
      end
      scan_en = '0;
      for (int g = 0; g < NI; g++) wait_idle(g, 300);
      repeat (5) @(posedge i_clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
